// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier for mult/multu; stalls the PC via busy.
// Optional MULT_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier is zero.
module mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] mplier;
  logic             neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] mplier_shr;
  logic [PW-1:0]    prod_step;
  logic [PW-1:0]    result;
  logic             last_step;

  logic             load;
  logic             step;
  logic             commit;
  logic             busy_nxt;
  logic             done_nxt;

  // Operand magnitudes; the most negative value maps onto itself as unsigned.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_op && a[WIDTH-1]) a_mag = WIDTH'(~a + WIDTH'(1));
    if (signed_op && b[WIDTH-1]) b_mag = WIDTH'(~b + WIDTH'(1));
  end

  // One shift-add step and the sign-corrected product it would commit.
  always_comb begin
    prod_step  = mplier[0] ? PW'(prod + mcand) : prod;
    mplier_shr = mplier >> 1;
    result     = neg ? PW'(~prod_step + PW'(1)) : prod_step;
    last_step  = (cnt == CNT_W'(WIDTH - 1));
`ifdef MULT_EARLY_EXIT_EN
    if (mplier_shr == '0) last_step = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath control decode.
  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    commit   = 1'b0;
    busy_nxt = (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE);
    case (state)
      S_IDLE: load = start;
      S_RUN: begin
        step   = 1'b1;
        commit = last_step;
      end
      S_DONE: load = start;
      default: ;
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Operand latch and shift-add datapath; a reset discards any partial product.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      prod   <= '0;
      neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      cnt    <= CNT_W'(cnt + CNT_W'(1));
      mcand  <= mcand << 1;
      mplier <= mplier_shr;
      prod   <= prod_step;
    end
  end

  // HI/LO change only on the RUN->DONE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= result[PW-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: expected products and latencies queued at start, checked at done.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } sb_t;

  sb_t sb_q[$];

`ifdef MULT_EARLY_EXIT_EN
  localparam int PULSE_AT = 1;
`else
  localparam int PULSE_AT = 10;
`endif

  mult_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Number of RUN edges before done is visible.
  function automatic int model_lat(input logic [31:0] y, input logic s);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m;
    int          top;
    m   = (s && y[31]) ? (~y + 32'd1) : y;
    top = 0;
    for (int i = 0; i < 32; i++) if (m[i]) top = i;
    return top + 1;
`else
    return (y === 32'hx) ? 0 : 32;
`endif
  endfunction

  // Drive start for one edge (edge 0) and queue the expectation.
  task automatic go(input logic [31:0] x, input logic [31:0] y, input logic s);
    sb_t e;
    a         = x;
    b         = y;
    signed_op = s;
    start     = 1'b1;
    e.prod    = model_prod(x, y, s);
    e.lat     = model_lat(y, s);
    sb_q.push_back(e);
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; n0 = edges already elapsed since the start edge.
  task automatic wait_done(input string tag, input int n0);
    sb_t e;
    int  n;
    int  busy_low;
    bit  seen;
    n        = n0;
    busy_low = 0;
    seen     = 1'b0;
    while (n < 40) begin
      tick();
      n++;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_low++;
    end
    e.prod = 64'hx;
    e.lat  = -1;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(e.lat));
    check({tag, " busy_gap"}, 64'(busy_low), 64'd0);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(e.prod[63:32]));
    check({tag, " lo"}, 64'(lo), 64'(e.prod[31:0]));
  endtask

  task automatic no_second_done(input string tag);
    tick();
    check({tag, " done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    sb_t   dropped;
    string tg;
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick();

    // Unsigned 3*5
    go(32'd3, 32'd5, 1'b0);
    check("t1 busy_after_start", 64'(busy), 64'd1);
    wait_done("t1", 0);
    check("t1 lo_const", 64'(lo), 64'h0F);
    no_second_done("t1");
    check("t1 idle_busy", 64'(busy), 64'd0);

    // Signed corner cases
    go(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done("t2a", 0);
    check("t2a hi_const", 64'(hi), 64'hFFFF_FFFF);
    go(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done("t2b", 0);
    check("t2b hi_const", 64'(hi), 64'h4000_0000);

    // All-ones unsigned vs signed
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("t3a", 0);
    check("t3a hi_const", 64'(hi), 64'hFFFF_FFFE);
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("t3b", 0);
    check("t3b lo_const", 64'(lo), 64'd1);

    // start during RUN ignored, then back-to-back start from DONE
    go(32'd7, 32'd6, 1'b0);
    for (int i = 0; i < PULSE_AT; i++) tick();
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4 busy_after_pulse", 64'(busy), 64'd1);
    wait_done("t4a", PULSE_AT + 1);
    check("t4a lo_const", 64'(lo), 64'd42);
    go(32'd2, 32'd2, 1'b0);
    check("t4 b2b_busy", 64'(busy), 64'd1);
    check("t4 hold_lo", 64'(lo), 64'd42);
    wait_done("t4b", 0);
    check("t4b lo_const", 64'(lo), 64'd4);
    no_second_done("t4b");

    // Reset mid-RUN discards the operation
    go(32'h1234, 32'h10, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dropped = sb_q.pop_back();
    check("t5 busy", 64'(busy), 64'd0);
    check("t5 done", 64'(done), 64'd0);
    check("t5 hi", 64'(hi), 64'd0);
    check("t5 lo", 64'(lo), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t5 stays_idle", 64'(busy), 64'd0);
    go(32'h1234, 32'h10, 1'b0);
    wait_done("t5b", 0);
    check("t5b lo_const", 64'(lo), 64'h12340);

    // Multiplier of zero, then a few random operations
    go(32'd100, 32'd0, 1'b0);
    wait_done("t6 zero", 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      go($urandom, $urandom, 1'($urandom_range(0, 1)));
      a = $urandom;
      b = $urandom;
      tg = $sformatf("rnd%0d", i);
      wait_done(tg, 0);
    end
    no_second_done("rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Sequential radix-2 shift-add multiplier controller for the single-cycle MIPS core.
- Executes mult/multu (R-type funct 24/25) over multiple cycles.
- Holds the PC via busy while it runs.
- Writes the HI/LO result registers read by mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, 6, step counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- signed_op  input  1  1 = mult (two's complement), 0 = multu.
- a  input  WIDTH  multiplicand (rs data).
- b  input  WIDTH  multiplier (rt data).
- busy  output  1  high while RUN; drives the PC stall.
- done  output  1  high for exactly one cycle (DONE state).
- hi  output  WIDTH  upper product half.
- lo  output  WIDTH  lower product half.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All state changes on rising clk.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal product/multiplicand/multiplier registers=0.
- States: IDLE, RUN, DONE.
- IDLE + start: latch operands and enter RUN, counter=0.
  - Latch mcand = |a| zero-extended to 2*WIDTH, mplier = |b|, prod=0.
  - Latch neg = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]).
  - When signed_op=0, magnitudes are the raw operands.
- Magnitude of the most negative value (0x80000000) is 0x80000000 as unsigned; no overflow.
- RUN, each cycle:
  - If mplier[0], prod += mcand (2*WIDTH bits, no carry out possible).
  - Then mcand <<= 1, mplier >>= 1, counter += 1.
- RUN exit: on the edge where counter == WIDTH-1 (WIDTH steps total), go to DONE.
  - On the same edge, {hi,lo} = neg ? -(final prod) : final prod, where final prod includes that last step.
- Latency: start sampled at edge 0; done high in the cycle after edge WIDTH; busy high between edge 0 and edge WIDTH.
- DONE: done=1 for one cycle. Next state is IDLE, or RUN if start=1, with new operands latched exactly as from IDLE.
- start during RUN: ignored. No queueing; operands are not re-latched.
- hi/lo hold their value from the DONE transition until the next DONE transition or reset. They are never changed during RUN.
- reset mid-RUN: abort immediately to IDLE. Outputs take reset values and the partial product is discarded.
- reset and start in the same cycle: reset wins.
- a/b/signed_op may change freely after the latch cycle without effect.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined: RUN also exits to DONE on any edge where the updated mplier is zero. Applies after any step, including counter < WIDTH-1. hi/lo, the sign fix and done timing relative to that edge are unchanged.
  - b == 0: first RUN edge goes to DONE with product 0, so done appears 2 cycles after start.
- Not defined: always exactly WIDTH RUN cycles; no mplier zero-detect logic is synthesized.

Test Plan:
1. Unsigned, a=3, b=5, start one cycle -> busy high 32 cycles, then done one cycle, hi=0x00000000, lo=0x0000000F. No second done pulse.
2. Signed, a=0xFFFFFFFF (-1), b=0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. Signed, a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
3. Unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands with signed_op=1 -> hi=0, lo=1.
4. Start 7*6 unsigned, then pulse start with a=9, b=9 at RUN cycle 10 -> pulse ignored, result lo=42. Start asserted during the done cycle with 2*2 -> back-to-back RUN, next result lo=4, hi/lo=42 until then.
5. Start 0x1234*0x10, assert reset at RUN cycle 5 -> next cycle busy=0, done=0, hi=lo=0, state IDLE. A new start then completes normally with lo=0x12340.
6. With MULT_EARLY_EXIT_EN: 3*5 -> done in the cycle after edge 3, lo=15. 100*0 -> done 2 cycles after start, lo=0. Without the macro, the same cases take the full 32 RUN cycles.
